key_debounce_pulse: RTL and testbench
=====================================

KEY_DEBOUNCE_PULSE -- requirements
Module: key_debounce_pulse

Interface
REQ-001 Parameter DB_CYCLES, default 1_000_000, sets consecutive stable sys_clk cycles to accept a press or release (20 ms at 50 MHz).
REQ-002 Parameter HOLD_CYCLES, default 25_000_000, sets cycles in HELD before auto-repeat starts (500 ms).
REQ-003 Parameter REPEAT_CYCLES, default 5_000_000, sets the auto-repeat pulse period (100 ms).
REQ-004 sys_clk  in  1  single system clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low; reset=0 clears all state immediately, release is synchronous to sys_clk.
REQ-006 key_in  in  1  raw push-button level, active-high, asynchronous to sys_clk, may bounce.
REQ-007 repeat_en  in  1  1 = auto-repeat allowed while the key is held.
REQ-008 key_level  out  1  debounced key level, registered.
REQ-009 key_pulse  out  1  one-cycle pulse per accepted press and per repeat tick; drives a downstream counter's enable.
REQ-010 key_release  out  1  one-cycle pulse per accepted release.

Function
REQ-011 key_in passes through a 2-flop synchronizer; only the synchronized value (ksync) feeds the FSM.
REQ-012 FSM states: IDLE, PRESS_CHK, HELD, REPEAT, RELEASE_CHK; one shared cycle counter cnt, width $clog2 of the largest parameter.
REQ-013 IDLE: key_level=0; ksync=1 -> PRESS_CHK, cnt=0.
REQ-014 PRESS_CHK: ksync=1 -> cnt+1; ksync=0 at any count -> IDLE, no output activity (bounce rejected).
REQ-015 PRESS_CHK with cnt=DB_CYCLES-1 and ksync=1 -> HELD, cnt=0, key_level=1, key_pulse=1 for exactly the next cycle.
REQ-016 Press latency: key_pulse rises exactly DB_CYCLES+3 rising edges after the first edge sampling key_in=1, for clean input.
REQ-017 HELD: ksync=0 -> RELEASE_CHK, cnt=0; with repeat_en=1, cnt reaching HOLD_CYCLES-1 -> REPEAT, cnt=0, key_pulse=1 one cycle; repeat_en=0 holds cnt at 0.
REQ-018 REPEAT: key_pulse=1 one cycle each time cnt reaches REPEAT_CYCLES-1, then cnt=0; ksync=0 -> RELEASE_CHK, cnt=0; repeat_en=0 -> HELD, cnt=0, no pulse.
REQ-019 RELEASE_CHK: ksync=0 for DB_CYCLES consecutive cycles -> IDLE, key_level=0, key_release=1 one cycle; ksync=1 earlier -> HELD, cnt=0, no key_pulse.
REQ-020 key_pulse and key_release never high in the same cycle; neither is high two consecutive cycles.
REQ-021 cnt never wraps; it saturates at the terminal value of the current state until the state changes.
REQ-022 Simultaneous ksync drop and repeat terminal count in REPEAT: the release check wins, no pulse.

Reset
REQ-023 On reset=0: state=IDLE, cnt=0, synchronizer flops=0, key_level=0, key_pulse=0, key_release=0.
REQ-024 Reset asserted mid-press or mid-repeat aborts with no pulse; after release, a key still held is re-qualified from IDLE with full DB_CYCLES debounce.

Structure
REQ-025 Package key_pkg holds the key_state_t enum and the default DB/HOLD/REPEAT cycle constants.
REQ-026 One sub-module, sync_2ff (1-bit, reset-clearable, same sys_clk/reset ports), implements REQ-011.
REQ-027 All outputs are driven from flops; no combinational path from key_in to any output.

Verification (DB_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=5)
REQ-028 Clean press held 10 cycles then released -> exactly one key_pulse at edge 7, key_level 1, one key_release after the release debounce, repeat_en=0.
REQ-029 Bounce 1,0,1,0 each 2 cycles then stable 1 -> no pulse during the bounce, exactly one key_pulse 7 edges after the last 0->1.
REQ-030 repeat_en=1, key held 60 cycles -> initial pulse, first repeat 20 cycles later, then pulses every 5 cycles until the release.
REQ-031 Release glitch 0 for 2 cycles inside HELD -> no key_release, no extra key_pulse, key_level stays 1.
REQ-032 reset=0 pulsed asynchronously (between edges) during REPEAT -> all outputs 0 immediately; the key still held gives one fresh pulse 7 edges after reset release.
REQ-033 Drop repeat_en mid-REPEAT -> pulses stop, key_level stays 1, re-asserting restarts the HOLD_CYCLES wait.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and default timing constants for the push-button debouncer.
package key_pkg;

  // Debouncer FSM states.
  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_PRESS_CHK   = 3'd1,
    ST_HELD        = 3'd2,
    ST_REPEAT      = 3'd3,
    ST_RELEASE_CHK = 3'd4
  } key_state_t;

  // Defaults for a 50 MHz sys_clk: 20 ms debounce, 500 ms hold, 100 ms repeat.
  localparam int DEF_DB_CYCLES     = 1_000_000;
  localparam int DEF_HOLD_CYCLES   = 25_000_000;
  localparam int DEF_REPEAT_CYCLES = 5_000_000;

  // Width of the shared counter: enough to reach (largest period - 1), never zero.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; clears on reset.
module sync_2ff
  import key_pkg::*;
(
  input  logic sys_clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Capture the raw level, then re-time it once more to settle metastability.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/key_debounce_pulse.sv
// Push-button debouncer with press/release pulses and optional auto-repeat.
// The raw key is synchronized, then a single FSM with one shared counter
// qualifies presses and releases and times the hold and repeat periods.
module key_debounce_pulse
  import key_pkg::*;
#(
  parameter int DB_CYCLES     = DEF_DB_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic sys_clk,
  input  logic reset,
  input  logic key_in,
  input  logic repeat_en,
  output logic key_level,
  output logic key_pulse,
  output logic key_release
);

  localparam int CNT_W = cnt_width(DB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);

  // Terminal counts are "period - 1" because the counter starts at zero.
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  logic             ksync_s;
  key_state_t       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             key_level_r;
  logic             key_pulse_r;
  logic             key_release_r;

  sync_2ff u_sync (
    .sys_clk (sys_clk),
    .reset   (reset),
    .d       (key_in),
    .q       (ksync_s)
  );

  // Debounce FSM: state, shared counter and all registered outputs.
  // Terminal tests use >= so the counter can never run past its limit.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      cnt_r         <= CNT_ZERO;
      key_level_r   <= 1'b0;
      key_pulse_r   <= 1'b0;
      key_release_r <= 1'b0;
    end else begin
      key_pulse_r   <= 1'b0;
      key_release_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          key_level_r <= 1'b0;
          cnt_r       <= CNT_ZERO;
          if (ksync_s) begin
            state_r <= ST_PRESS_CHK;
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_PRESS_CHK: begin
          if (!ksync_s) begin
            // Bounce: drop back silently.
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
          end else if (cnt_r >= DB_LAST) begin
            state_r     <= ST_HELD;
            cnt_r       <= CNT_ZERO;
            key_level_r <= 1'b1;
            key_pulse_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end

        ST_HELD: begin
          key_level_r <= 1'b1;
          if (!ksync_s) begin
            state_r <= ST_RELEASE_CHK;
            cnt_r   <= CNT_ZERO;
          end else if (!repeat_en) begin
            // Hold timer only runs while repeat is allowed.
            cnt_r <= CNT_ZERO;
          end else if (cnt_r >= HOLD_LAST) begin
            state_r     <= ST_REPEAT;
            cnt_r       <= CNT_ZERO;
            key_pulse_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end

        ST_REPEAT: begin
          key_level_r <= 1'b1;
          if (!ksync_s) begin
            // Release check takes priority over a coincident repeat tick.
            state_r <= ST_RELEASE_CHK;
            cnt_r   <= CNT_ZERO;
          end else if (!repeat_en) begin
            state_r <= ST_HELD;
            cnt_r   <= CNT_ZERO;
          end else if (cnt_r >= REP_LAST) begin
            cnt_r       <= CNT_ZERO;
            key_pulse_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end

        ST_RELEASE_CHK: begin
          if (ksync_s) begin
            // Release glitch: key is still down, resume holding without a pulse.
            state_r     <= ST_HELD;
            cnt_r       <= CNT_ZERO;
            key_level_r <= 1'b1;
          end else if (cnt_r >= DB_LAST) begin
            state_r       <= ST_IDLE;
            cnt_r         <= CNT_ZERO;
            key_level_r   <= 1'b0;
            key_release_r <= 1'b1;
          end else begin
            cnt_r       <= cnt_r + CNT_ONE;
            key_level_r <= 1'b1;
          end
        end

        default: begin
          state_r     <= ST_IDLE;
          cnt_r       <= CNT_ZERO;
          key_level_r <= 1'b0;
        end
      endcase
    end
  end

  assign key_level   = key_level_r;
  assign key_pulse   = key_pulse_r;
  assign key_release = key_release_r;

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Self-checking bench for key_debounce_pulse with short timing parameters.
module tb_key_debounce_pulse;

  localparam int DB  = 4;
  localparam int HLD = 20;
  localparam int REP = 5;

  logic sys_clk;
  logic reset;
  logic key_in;
  logic repeat_en;
  logic key_level;
  logic key_pulse;
  logic key_release;

  int n_cmp;
  int n_fail;

  typedef struct packed {
    logic key;
    logic ren;
    logic lvl;
    logic pls;
    logic rel;
  } vec_t;

  vec_t vecs[$];

  key_debounce_pulse #(
    .DB_CYCLES     (DB),
    .HOLD_CYCLES   (HLD),
    .REPEAT_CYCLES (REP)
  ) dut (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .key_in      (key_in),
    .repeat_en   (repeat_en),
    .key_level   (key_level),
    .key_pulse   (key_pulse),
    .key_release (key_release)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic add_n(input int n, input logic k, input logic r,
                       input logic l, input logic p, input logic rl);
    vec_t v;
    v.key = k; v.ren = r; v.lvl = l; v.pls = p; v.rel = rl;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    int first_edge;
    int pulse_cnt;
    n_cmp     = 0;
    n_fail    = 0;
    reset     = 1'b0;
    key_in    = 1'b0;
    repeat_en = 1'b0;

    // Row j: inputs applied before edge j+1, outputs checked after edge j+1.
    // Clean press held 10 cycles, no repeat: pulse at edge 7, release at edge 17.
    add_n(6, 1, 0, 0, 0, 0);
    add_n(1, 1, 0, 1, 1, 0);
    add_n(3, 1, 0, 1, 0, 0);
    add_n(6, 0, 0, 1, 0, 0);
    add_n(1, 0, 0, 0, 0, 1);
    add_n(3, 0, 0, 0, 0, 0);
    // Bounce 1,0,1,0 in pairs, then stable: pulse 7 edges after last rise.
    add_n(2, 1, 0, 0, 0, 0);
    add_n(2, 0, 0, 0, 0, 0);
    add_n(2, 1, 0, 0, 0, 0);
    add_n(2, 0, 0, 0, 0, 0);
    add_n(6, 1, 0, 0, 0, 0);
    add_n(1, 1, 0, 1, 1, 0);
    add_n(3, 1, 0, 1, 0, 0);
    // Two-cycle release glitch inside HELD: nothing changes.
    add_n(2, 0, 0, 1, 0, 0);
    add_n(6, 1, 0, 1, 0, 0);
    add_n(6, 0, 0, 1, 0, 0);
    add_n(1, 0, 0, 0, 0, 1);
    add_n(3, 0, 0, 0, 0, 0);
    // Auto-repeat: pulse at 7, repeat at 27, then every 5 until release.
    add_n(6, 1, 1, 0, 0, 0);
    add_n(1, 1, 1, 1, 1, 0);
    add_n(19, 1, 1, 1, 0, 0);
    for (int k = 0; k < 7; k++) begin
      add_n(1, 1, 1, 1, 1, 0);
      add_n(4, 1, 1, 1, 0, 0);
    end
    add_n(1, 0, 1, 1, 1, 0);
    add_n(5, 0, 1, 1, 0, 0);
    add_n(1, 0, 1, 0, 0, 1);
    add_n(3, 0, 0, 0, 0, 0);
    // Release seen on the same edge as a repeat terminal count: no pulse.
    add_n(6, 1, 1, 0, 0, 0);
    add_n(1, 1, 1, 1, 1, 0);
    add_n(19, 1, 1, 1, 0, 0);
    add_n(1, 1, 1, 1, 1, 0);
    add_n(4, 1, 1, 1, 0, 0);
    add_n(1, 1, 1, 1, 1, 0);
    add_n(2, 1, 1, 1, 0, 0);
    add_n(6, 0, 1, 1, 0, 0);
    add_n(1, 0, 1, 0, 0, 1);
    add_n(3, 0, 0, 0, 0, 0);
    // Drop repeat_en mid-REPEAT, re-assert: full hold wait restarts.
    add_n(6, 1, 1, 0, 0, 0);
    add_n(1, 1, 1, 1, 1, 0);
    add_n(19, 1, 1, 1, 0, 0);
    add_n(1, 1, 1, 1, 1, 0);
    add_n(4, 1, 1, 1, 0, 0);
    add_n(1, 1, 1, 1, 1, 0);
    add_n(1, 1, 1, 1, 0, 0);
    add_n(7, 1, 0, 1, 0, 0);
    add_n(19, 1, 1, 1, 0, 0);
    add_n(1, 1, 1, 1, 1, 0);
    add_n(6, 0, 1, 1, 0, 0);
    add_n(1, 0, 1, 0, 0, 1);
    add_n(3, 0, 0, 0, 0, 0);

    // Reset state.
    #12;
    check_bit("reset key_level", key_level, 1'b0);
    check_bit("reset key_pulse", key_pulse, 1'b0);
    check_bit("reset key_release", key_release, 1'b0);
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    reset = 1'b1;

    // Table-driven vectors.
    for (int j = 0; j < vecs.size(); j++) begin
      key_in    = vecs[j].key;
      repeat_en = vecs[j].ren;
      @(posedge sys_clk);
      @(negedge sys_clk);
      check_bit($sformatf("vec%0d key_level", j), key_level, vecs[j].lvl);
      check_bit($sformatf("vec%0d key_pulse", j), key_pulse, vecs[j].pls);
      check_bit($sformatf("vec%0d key_release", j), key_release, vecs[j].rel);
    end

    // Asynchronous reset during REPEAT, just before a repeat tick at edge 32.
    key_in    = 1'b1;
    repeat_en = 1'b1;
    repeat (31) @(posedge sys_clk);
    #1;
    check_bit("pre-reset key_level", key_level, 1'b1);
    #1;
    reset = 1'b0;
    #1;
    check_bit("async reset key_level", key_level, 1'b0);
    check_bit("async reset key_pulse", key_pulse, 1'b0);
    check_bit("async reset key_release", key_release, 1'b0);
    @(posedge sys_clk);
    #1;
    check_bit("in reset aborted pulse", key_pulse, 1'b0);
    @(negedge sys_clk);
    reset = 1'b1;
    first_edge = 0;
    pulse_cnt  = 0;
    for (int e = 1; e <= 20; e++) begin
      @(posedge sys_clk);
      #1;
      if (key_pulse === 1'b1) begin
        pulse_cnt++;
        if (first_edge == 0) first_edge = e;
      end
    end
    check_int("post-reset pulse edge", first_edge, 7);
    check_int("post-reset pulse count", pulse_cnt, 1);
    check_bit("post-reset key_level", key_level, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
